// File: rtl/simon_tone_sequencer.sv
// Simon tone sequencer: plays pattern-memory colour sequences or single tones by
// steering the square-wave oscillator half-period and its reset (silence) line.
`timescale 1ns/1ps
module simon_tone_sequencer #(
  parameter logic [25:0] NOTE_CYCLES = 26'd21_000_000,
  parameter logic [25:0] GAP_CYCLES  = 26'd2_500_000,
  parameter logic [19:0] HW_GREEN    = 20'd60240,
  parameter logic [19:0] HW_RED      = 20'd80644,
  parameter logic [19:0] HW_YELLOW   = 20'd99205,
  parameter logic [19:0] HW_BLUE     = 20'd119616
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  seq_len,
  input  logic        play_req,
  input  logic [1:0]  play_color,
  input  logic        abort,
  output logic [4:0]  rd_addr,
  input  logic [1:0]  rd_data,
  output logic [19:0] half_wav,
  output logic        osc_reset,
  output logic        tone_on,
  output logic [1:0]  color,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    TONE  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t      state_q;
  logic [4:0]  rd_addr_q;
  logic [19:0] half_wav_q;
  logic [1:0]  color_q;
  logic [4:0]  index_q;
  logic [4:0]  len_q;
  logic [25:0] timer_q;
  logic        tone_on_q;
  logic        busy_q;
  logic        done_q;
  logic        single_q;

  function automatic logic [19:0] tone_half(input logic [1:0] c);
    logic [19:0] hw;
    case (c)
      2'd0:    hw = HW_GREEN;
      2'd1:    hw = HW_RED;
      2'd2:    hw = HW_YELLOW;
      2'd3:    hw = HW_BLUE;
      default: hw = 20'd0;
    endcase
    return hw;
  endfunction

  // Sequencer FSM; every output except osc_reset comes straight from a register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_addr_q  <= 5'd0;
      half_wav_q <= 20'd0;
      color_q    <= 2'd0;
      index_q    <= 5'd0;
      len_q      <= 5'd0;
      timer_q    <= 26'd0;
      tone_on_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      single_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q    <= IDLE;
        tone_on_q  <= 1'b0;
        half_wav_q <= 20'd0;
        busy_q     <= 1'b0;
        single_q   <= 1'b0;
        timer_q    <= 26'd0;
      end else begin
        case (state_q)
          IDLE: begin
            // start with a zero length is ignored, so a coincident play_req still gets served
            if (start && (seq_len != 5'd0)) begin
              len_q     <= seq_len;
              index_q   <= 5'd0;
              rd_addr_q <= 5'd0;
              busy_q    <= 1'b1;
              single_q  <= 1'b0;
              state_q   <= FETCH;
            end else if (play_req) begin
              color_q    <= play_color;
              half_wav_q <= tone_half(play_color);
              single_q   <= 1'b1;
              timer_q    <= NOTE_CYCLES - 26'd1;
              tone_on_q  <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= TONE;
            end else begin
              busy_q <= 1'b0;
            end
          end
          FETCH: begin
            color_q    <= rd_data;
            half_wav_q <= tone_half(rd_data);
            tone_on_q  <= 1'b1;
            timer_q    <= NOTE_CYCLES - 26'd1;
            state_q    <= TONE;
          end
          TONE: begin
            if (timer_q == 26'd0) begin
              tone_on_q  <= 1'b0;
              half_wav_q <= 20'd0;
              timer_q    <= GAP_CYCLES - 26'd1;
              state_q    <= GAP;
            end else begin
              timer_q <= timer_q - 26'd1;
            end
          end
          GAP: begin
            if (timer_q != 26'd0) begin
              timer_q <= timer_q - 26'd1;
            end else if (single_q || (index_q == (len_q - 5'd1))) begin
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              single_q <= 1'b0;
              state_q  <= IDLE;
            end else begin
              index_q   <= index_q + 5'd1;
              rd_addr_q <= index_q + 5'd1;
              state_q   <= FETCH;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign rd_addr   = rd_addr_q;
  assign half_wav  = half_wav_q;
  assign tone_on   = tone_on_q;
  assign color     = color_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign osc_reset = reset | ~tone_on_q;

endmodule
